// File: rtl/led_panel_pkg.sv
// Shared types and constants for the LED panel serial receive path.
package led_panel_pkg;

   localparam int unsigned LED_WORD_W   = 32;
   localparam int unsigned LED_NUM_ROWS = 4;

   typedef enum logic [1:0] {ROW_A, ROW_B, ROW_C, ROW_D} row_sel_t;

   typedef enum logic {RX_IDLE, RX_SHIFT} rx_state_t;

   typedef logic [LED_WORD_W-1:0] row_word_t;

endpackage

// File: rtl/led_sipo_word.sv
// MSB-first shift register with bit counter; done flags the bit that completes a word.
module led_sipo_word
   import led_panel_pkg::*;
#(
   parameter int unsigned WORD_W = LED_WORD_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              shift_en,
   input  logic              restart,
   input  logic              data_in,
   output logic [WORD_W-1:0] word_next,
   output logic              done
);

   localparam int unsigned CNT_W = $clog2(WORD_W) + 1;

   logic [WORD_W-1:0] word_q;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   assign word_next = {word_q[WORD_W-2:0], data_in};
   // restart makes the current bit bit 0 of a new word, so it can never complete one
   assign done      = shift_en && !restart && (cnt_q == CNT_W'(WORD_W - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (shift_en) begin
         if (restart) begin
            cnt_d = CNT_W'(1);
         end else if (done) begin
            cnt_d = '0;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         word_q <= '0;
         cnt_q  <= '0;
      end else begin
         cnt_q <= cnt_d;
         if (shift_en && !clear) begin
            word_q <= word_next;
         end
      end
   end

endmodule

// File: rtl/led_panel_sipo_rx.sv
// LED panel serial receiver: rebuilds four row words and publishes them atomically per frame.
// Optional LED_ROW_ORDER_CHECK_EN adds order_err and enforces row order A,B,C,D.
module led_panel_sipo_rx
   import led_panel_pkg::*;
#(
   parameter int unsigned WORD_W   = LED_WORD_W,
   parameter int unsigned NUM_ROWS = LED_NUM_ROWS
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              data_in,
   input  logic              bit_en,
   input  logic [1:0]        sel,
   input  logic              flush,
   output logic [WORD_W-1:0] row_a,
   output logic [WORD_W-1:0] row_b,
   output logic [WORD_W-1:0] row_c,
   output logic [WORD_W-1:0] row_d,
   output logic              row_done,
   output logic [1:0]        row_idx,
   output logic              frame_done,
   output logic              sel_err
`ifdef LED_ROW_ORDER_CHECK_EN
   ,
   output logic              order_err
`endif
);

   rx_state_t           state_q, state_d;
   row_sel_t            cur_sel_q;
   logic [NUM_ROWS-1:0] row_valid_q, row_valid_d;
   logic [WORD_W-1:0]   shadow_q [NUM_ROWS];
   logic [WORD_W-1:0]   row_a_q, row_b_q, row_c_q, row_d_q;
   logic [WORD_W-1:0]   word_next;
   logic [1:0]          row_idx_q;
   logic                row_done_q, frame_done_q, sel_err_q;
   logic                shift_en, restart, word_done, sel_chg, frame_commit, order_ok;

   // flush beats a simultaneous bit
   assign shift_en = bit_en && !flush;

   led_sipo_word #(
      .WORD_W (WORD_W)
   ) u_word (
      .clk       (clk),
      .rst       (rst),
      .clear     (flush),
      .shift_en  (shift_en),
      .restart   (restart),
      .data_in   (data_in),
      .word_next (word_next),
      .done      (word_done)
   );

   always_comb begin
      state_d = state_q;
      restart = 1'b0;
      sel_chg = 1'b0;
      case (state_q)
         RX_IDLE: begin
            if (shift_en) begin
               restart = 1'b1;
               state_d = RX_SHIFT;
            end
         end
         RX_SHIFT: begin
            if (shift_en) begin
               if (sel != cur_sel_q) begin
                  restart = 1'b1;
                  sel_chg = 1'b1;
               end else if (word_done) begin
                  state_d = RX_IDLE;
               end
            end
         end
         default: state_d = RX_IDLE;
      endcase
      if (flush) begin
         state_d = RX_IDLE;
      end
   end

   always_comb begin
      row_valid_d  = row_valid_q;
      frame_commit = 1'b0;
      if (flush) begin
         row_valid_d = '0;
      end else if (word_done) begin
         if (!order_ok) begin
            // out-of-order word restarts the frame; a row A is kept as its first row
            row_valid_d = '0;
            if (cur_sel_q == ROW_A) begin
               row_valid_d[0] = 1'b1;
            end
         end else begin
            row_valid_d[cur_sel_q] = 1'b1;
            if (cur_sel_q == ROW_D) begin
               row_valid_d  = '0;
               frame_commit = &row_valid_q[NUM_ROWS-2:0];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= RX_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cur_sel_q    <= ROW_A;
         row_valid_q  <= '0;
         row_done_q   <= 1'b0;
         frame_done_q <= 1'b0;
         sel_err_q    <= 1'b0;
         row_idx_q    <= '0;
         row_a_q      <= '0;
         row_b_q      <= '0;
         row_c_q      <= '0;
         row_d_q      <= '0;
         for (int i = 0; i < NUM_ROWS; i++) begin
            shadow_q[i] <= '0;
         end
      end else begin
         row_done_q   <= word_done;
         frame_done_q <= frame_commit;
         sel_err_q    <= sel_chg;
         row_valid_q  <= row_valid_d;
         if (restart) begin
            cur_sel_q <= row_sel_t'(sel);
         end
         if (word_done) begin
            shadow_q[cur_sel_q] <= word_next;
            row_idx_q           <= cur_sel_q;
         end
         // row D comes straight from the word being completed, not its shadow
         if (frame_commit) begin
            row_a_q <= shadow_q[0];
            row_b_q <= shadow_q[1];
            row_c_q <= shadow_q[2];
            row_d_q <= word_next;
         end
      end
   end

`ifdef LED_ROW_ORDER_CHECK_EN
   logic [1:0] expected_q, expected_d;
   logic       order_err_q;

   assign order_ok = (cur_sel_q == expected_q);

   always_comb begin
      expected_d = expected_q;
      if (flush) begin
         expected_d = 2'd0;
      end else if (word_done) begin
         if (!order_ok) begin
            expected_d = (cur_sel_q == ROW_A) ? 2'd1 : 2'd0;
         end else begin
            expected_d = expected_q + 2'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         expected_q  <= 2'd0;
         order_err_q <= 1'b0;
      end else begin
         expected_q  <= expected_d;
         order_err_q <= word_done && !order_ok;
      end
   end

   assign order_err = order_err_q;
`else
   assign order_ok = 1'b1;
`endif

   assign row_a      = row_a_q;
   assign row_b      = row_b_q;
   assign row_c      = row_c_q;
   assign row_d      = row_d_q;
   assign row_done   = row_done_q;
   assign row_idx    = row_idx_q;
   assign frame_done = frame_done_q;
   assign sel_err    = sel_err_q;

endmodule
